// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Bundles the fetch stage's control, redirect, program-load and IF/ID signals.
//   master : hazard/decode/loader side (drives controls, sees IF/ID outputs)
//   slave  : the instruction_fetch stage
// Signals:
//   enable, stall, flush, in_pc_src[1:0]   run/hazard control and next-PC select
//   in_pc_branch/jump/register[len]        redirect targets
//   wr_en, wr_addr[AW], wr_data[len]       instruction memory load port
//   out_pc_branch, out_instruccion, out_pc, out_halt
//   step (only with IF_STEP_MODE_EN)       single-step request while enable=0
// -----------------------------------------------------------------------------
interface instruction_fetch_if #(
  parameter int len = 32,
  parameter int AW  = 8
);
  logic           enable;
  logic           stall;
  logic           flush;
  logic [1:0]     in_pc_src;
  logic [len-1:0] in_pc_branch;
  logic [len-1:0] in_pc_jump;
  logic [len-1:0] in_pc_register;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [len-1:0] wr_data;
  logic [len-1:0] out_pc_branch;
  logic [len-1:0] out_instruccion;
  logic [len-1:0] out_pc;
  logic           out_halt;
`ifdef IF_STEP_MODE_EN
  logic           step;
`endif

  modport master (
`ifdef IF_STEP_MODE_EN
    output step,
`endif
    output enable, stall, flush, in_pc_src,
    output in_pc_branch, in_pc_jump, in_pc_register,
    output wr_en, wr_addr, wr_data,
    input  out_pc_branch, out_instruccion, out_pc, out_halt
  );

  modport slave (
`ifdef IF_STEP_MODE_EN
    input  step,
`endif
    input  enable, stall, flush, in_pc_src,
    input  in_pc_branch, in_pc_jump, in_pc_register,
    input  wr_en, wr_addr, wr_data,
    output out_pc_branch, out_instruccion, out_pc, out_halt
  );
endinterface

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: PC register, word-addressed instruction memory and the IF/ID
// pipeline register feeding decode. Handles branch/jump/jump-register
// redirects, hazard stall/flush, a debug program-load write port and a HALT
// opcode (6'b111111) that freezes the stage until reset.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    instruction_fetch_if.slave (controls, targets, load port, IF/ID out)
// Optional: define IF_STEP_MODE_EN to add bus.step; a rising edge on step
// while enable=0 advances exactly one fetch.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_RUN   | normal fetch, PC advances/redirects, IF/ID loads
// S_HALTED| HALT latched; PC frozen, IF/ID fed NOPs until reset
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int len        = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  instruction_fetch_if.slave bus
);

  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [len-1:0] r_pc;
  logic [len-1:0] r_pc_branch;
  logic [len-1:0] r_instr;
  logic [len-1:0] w_pc_nxt;
  logic [len-1:0] w_pc_branch_nxt;
  logic [len-1:0] w_instr_nxt;
  logic [len-1:0] w_pc_plus4;
  logic [len-1:0] w_word;
  logic [len-1:0] w_target;
  logic           w_redirect;
  logic           w_halt_fetch;
  logic           w_adv;

  logic [len-1:0] r_imem [IMEM_DEPTH];

  // Stage advance qualifier: enable, or a single-step edge when compiled in.
`ifdef IF_STEP_MODE_EN
  logic r_step_d;

  always_ff @(posedge clk) begin
    if (reset) r_step_d <= 1'b0;
    else       r_step_d <= bus.step;
  end

  assign w_adv = bus.enable | (bus.step & ~r_step_d);
`else
  assign w_adv = bus.enable;
`endif

  // Memory has no reset; writes land regardless of enable or state.
  always_ff @(posedge clk) begin
    if (bus.wr_en) r_imem[bus.wr_addr] <= bus.wr_data;
  end

  // PC bits above AW+1 are dropped so fetches wrap modulo IMEM_DEPTH.
  assign w_word     = r_imem[r_pc[AW+1:2]];
  assign w_pc_plus4 = r_pc + len'(4);
  assign w_redirect = (bus.in_pc_src != 2'b00);

  always_comb begin
    w_target = bus.in_pc_register;
    unique case (bus.in_pc_src)
      2'b01:   w_target = bus.in_pc_branch;
      2'b10:   w_target = bus.in_pc_jump;
      default: w_target = bus.in_pc_register;
    endcase
    w_target = w_target & ~len'(3);
  end

  // A HALT only counts when it is really latched: flush, stall or a redirect
  // in the same cycle all cancel it.
  assign w_halt_fetch = ~bus.flush & ~bus.stall & ~w_redirect &
                        (w_word[len-1 -: 6] == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_adv && r_state == S_RUN && w_halt_fetch) w_state_nxt = S_HALTED;
  end

  always_comb begin
    w_pc_nxt        = r_pc;
    w_pc_branch_nxt = r_pc_branch;
    w_instr_nxt     = r_instr;
    if (w_adv) begin
      unique case (r_state)
        S_RUN: begin
          // Redirect beats stall; a HALT freezes PC at its own address.
          if (w_redirect)                     w_pc_nxt = w_target;
          else if (!bus.stall && !w_halt_fetch) w_pc_nxt = w_pc_plus4;

          if (bus.flush) begin
            w_instr_nxt = '0;
          end else if (!bus.stall) begin
            w_instr_nxt     = w_word;
            w_pc_branch_nxt = w_pc_plus4;
          end
        end
        S_HALTED: w_instr_nxt = '0;
        default:  w_instr_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= '0;
      r_pc_branch <= '0;
      r_instr     <= '0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_pc_branch <= w_pc_branch_nxt;
      r_instr     <= w_instr_nxt;
    end
  end

  assign bus.out_pc          = r_pc;
  assign bus.out_pc_branch   = r_pc_branch;
  assign bus.out_instruccion = r_instr;
  assign bus.out_halt        = (r_state == S_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Scoreboard bench: the driver predicts each edge's IF/ID/PC/halt result from
// a behavioural model and queues it; a monitor compares after every edge.
// Directed scenarios follow the fetch-stage test plan, then random traffic.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcb;
    logic [31:0] ins;
    logic        halt;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model state
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_pcb, m_ins;
  bit          m_halted;
  bit          m_prev_step;

  instruction_fetch_if #(.len(32), .AW(8)) bus ();

  instruction_fetch #(.len(32), .IMEM_DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_pc",   bus.out_pc,                 e.pc);
        chk("sb_pcb",  bus.out_pc_branch,          e.pcb);
        chk("sb_ins",  bus.out_instruccion,        e.ins);
        chk("sb_halt", {31'd0, bus.out_halt},      {31'd0, e.halt});
      end
    end
  end

  // Drive one clock cycle, predict its result, queue it, return at negedge.
  task automatic cyc(input bit rst, input bit en, input bit stl, input bit fl,
                     input bit [1:0] src, input bit [31:0] pb, input bit [31:0] pj,
                     input bit [31:0] pr, input bit we, input bit [7:0] wa,
                     input bit [31:0] wd, input bit stp);
    exp_t e;
    bit adv;
    bit halts;
    logic [31:0] word, tgt;
    reset              = rst;
    bus.enable         = en;
    bus.stall          = stl;
    bus.flush          = fl;
    bus.in_pc_src      = src;
    bus.in_pc_branch   = pb;
    bus.in_pc_jump     = pj;
    bus.in_pc_register = pr;
    bus.wr_en          = we;
    bus.wr_addr        = wa;
    bus.wr_data        = wd;
    adv = en;
`ifdef IF_STEP_MODE_EN
    bus.step = stp;
    adv = en || (stp && !m_prev_step);
`endif
    m_prev_step = rst ? 1'b0 : stp;
    if (rst) begin
      m_pc = 0; m_pcb = 0; m_ins = 0; m_halted = 0;
    end else if (adv) begin
      if (m_halted) begin
        m_ins = 0;
      end else begin
        word  = m_mem[(m_pc / 4) % 256];
        tgt   = (src == 2'd1) ? pb : (src == 2'd2) ? pj : pr;
        tgt   = tgt & 32'hFFFF_FFFC;
        halts = !fl && !stl && src == 2'd0 && (word >> 26) == 32'h3F;
        if (fl) m_ins = 0;
        else if (!stl) begin m_ins = word; m_pcb = m_pc + 4; end
        if (src != 2'd0)         m_pc = tgt;
        else if (!stl && !halts) m_pc = m_pc + 4;
        m_halted = halts;
      end
    end
    if (we) m_mem[wa] = wd;
    e.pc = m_pc; e.pcb = m_pcb; e.ins = m_ins; e.halt = m_halted;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit en, input bit stl, input bit fl);
    for (int i = 0; i < n; i++) cyc(0, en, stl, fl, 2'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redir(input bit [1:0] src, input bit [31:0] tgt, input bit stl, input bit fl);
    cyc(0, 1, stl, fl, src, tgt, tgt, tgt, 0, 0, 0, 0);
  endtask

  logic [31:0] prog [4];
  logic [31:0] w;
  logic [31:0] p;

  initial begin
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0007;
    prog[2] = 32'h0022_1820; prog[3] = 32'hFC00_0000;
    for (int i = 0; i < 256; i++) m_mem[i] = 0;
    m_pc = 0; m_pcb = 0; m_ins = 0; m_halted = 0; m_prev_step = 0;
    reset = 1; bus.enable = 0; bus.stall = 0; bus.flush = 0; bus.in_pc_src = 0;
    bus.in_pc_branch = 0; bus.in_pc_jump = 0; bus.in_pc_register = 0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
`ifdef IF_STEP_MODE_EN
    bus.step = 0;
`endif
    @(negedge clk);

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pc",   bus.out_pc, 0);
    chk("rst_pcb",  bus.out_pc_branch, 0);
    chk("rst_ins",  bus.out_instruccion, 0);
    chk("rst_halt", {31'd0, bus.out_halt}, 0);

    // Program load with the stage frozen; filler words never carry HALT
    for (int i = 0; i < 256; i++) begin
      if (i < 4) w = prog[i];
      else begin
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'(i), w, 0);
    end
    chk("load_frozen_pc", bus.out_pc, 0);

    // Straight-line fetch into HALT
    for (int k = 0; k < 4; k++) begin
      run(1, 1, 0, 0);
      chk("seq_ins", bus.out_instruccion, prog[k]);
      chk("seq_pcb", bus.out_pc_branch, 32'((k + 1) * 4));
    end
    chk("halt_set", {31'd0, bus.out_halt}, 1);
    chk("halt_pc",  bus.out_pc, 32'd12);
    run(10, 1, 0, 0);
    chk("halted_pc",  bus.out_pc, 32'd12);
    chk("halted_ins", bus.out_instruccion, 0);
    redir(2'd1, 32'h80, 0, 1);
    chk("halted_ignores_redirect", bus.out_pc, 32'd12);

    // Stall at PC=8
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(2, 1, 0, 0);
    chk("pre_stall_pc", bus.out_pc, 32'd8);
    for (int k = 0; k < 2; k++) begin
      run(1, 1, 1, 0);
      chk("stall_pc",  bus.out_pc, 32'd8);
      chk("stall_ins", bus.out_instruccion, prog[1]);
    end
    run(1, 1, 0, 0);
    chk("resume_ins", bus.out_instruccion, prog[2]);

    // Branch with flush and stall together
    redir(2'd1, 32'h40, 1, 1);
    chk("br_pc",  bus.out_pc, 32'h40);
    chk("br_ins", bus.out_instruccion, 0);
    run(1, 1, 0, 0);
    chk("br_tgt_ins", bus.out_instruccion, m_mem[16]);
    chk("br_tgt_pcb", bus.out_pc_branch, 32'h44);

    // PC wrap and memory address wrap
    redir(2'd3, 32'hFFFF_FFFF, 0, 0);
    chk("jr_mask", bus.out_pc, 32'hFFFF_FFFC);
    run(1, 1, 0, 0);
    chk("pc_wrap", bus.out_pc, 0);
    redir(2'd2, 32'h400, 0, 0);
    run(1, 1, 0, 0);
    chk("mem_wrap", bus.out_instruccion, prog[0]);

    // Frozen stage still accepts memory writes
    p = bus.out_pc;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'd5, 32'hDEAD_BEEF, 0);
    run(4, 0, 0, 0);
    chk("freeze_pc", bus.out_pc, p);
    redir(2'd2, 32'h14, 0, 0);
    run(1, 1, 0, 0);
    chk("freeze_write", bus.out_instruccion, 32'hDEAD_BEEF);

`ifdef IF_STEP_MODE_EN
    p = bus.out_pc;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("step_pulse", bus.out_pc, p + 4);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("step_held", bus.out_pc, p + 8);
`endif

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit rst, we;
      bit [1:0] src;
      rst = ($urandom % 100) == 0;
      we  = !rst && (($urandom % 4) == 0);
      src = (($urandom % 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      w   = (($urandom % 8) == 0) ? (32'hFC00_0000 | ($urandom & 32'h03FF_FFFF)) : $urandom;
      cyc(rst, ($urandom % 8) != 0, ($urandom % 5) == 0, ($urandom % 6) == 0, src,
          $urandom, $urandom, $urandom, we, 8'($urandom), w, ($urandom % 3) == 0);
    end

    chk("sb_drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Pipeline stage directly upstream of decode. Holds the PC, a word-addressed instruction memory and the IF/ID pipeline register.
- Drives decode's in_pc_branch (PC+4) and in_instruccion.
- Takes redirect targets back from decode/execute: branch, jump and jump-register.
- Supports stall and flush from hazard logic, a program-load write port for the debug loader, and a HALT-opcode stop.

Parameters:
- len, 32, datapath/PC width.
- IMEM_DEPTH, 256, instruction memory depth in words.
- AW, $clog2(IMEM_DEPTH), word-address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global run enable; low freezes the stage.
- stall  in  1  hazard stall; hold PC and IF/ID.
- flush  in  1  squash IF/ID (load NOP).
- in_pc_src  in  2  00 sequential, 01 branch, 10 jump, 11 jump-register.
- in_pc_branch  in  len  branch target.
- in_pc_jump  in  len  jump target.
- in_pc_register  in  len  jump-register target.
- wr_en  in  1  instruction memory write strobe.
- wr_addr  in  AW  word address for the write.
- wr_data  in  len  instruction word to write.
- out_pc_branch  out  len  registered PC+4 of the fetched instruction; feeds decode in_pc_branch.
- out_instruccion  out  len  registered instruction; feeds decode in_instruccion.
- out_pc  out  len  current PC, for debug.
- out_halt  out  1  high while in HALTED.

Behaviour:
- Reset (synchronous, active-high):
  - PC=0, out_pc_branch=0, out_instruccion=0 (NOP), out_halt=0, state=RUN.
  - Memory contents are not cleared.
- Memory:
  - Read is combinational: word = imem[PC[AW+1:2]]. PC bits above AW+1 are ignored, so addressing wraps modulo IMEM_DEPTH.
  - Write on the clock edge when wr_en, in any state and regardless of enable.
  - A fetch in the same cycle as a write to the same address sees the old word.
- PC arithmetic: PC+4 wraps modulo 2^len. PC[1:0] is always 0 (targets are taken with bits [1:0] forced to 0).
- Next-PC select:
  - in_pc_src 00 → PC+4.
  - 01 → in_pc_branch.
  - 10 → in_pc_jump.
  - 11 → in_pc_register.
- State RUN, enable=1, per edge, in priority order:
  1. in_pc_src != 00: PC <= selected target, even when stall=1.
  2. stall=1 and in_pc_src==00: PC holds.
  3. Otherwise: PC <= PC+4.
- IF/ID register in RUN, enable=1:
  - flush=1: out_instruccion <= 0; out_pc_branch holds. Flush overrides stall.
  - Else stall=1: IF/ID holds.
  - Else: out_instruccion <= word, out_pc_branch <= PC+4.
- HALT detection:
  - Condition: in RUN, the word being latched (not flushed, not stalled) has opcode [31:26] == 6'b111111.
  - Latch it into IF/ID, freeze PC at its current value (not PC+4) and go to HALTED.
  - out_halt=1 from the next cycle.
- Flush or redirect in the same cycle as a HALT fetch: the flush/redirect wins, no halt is taken, and the state stays RUN.
- State HALTED:
  - PC frozen; out_instruccion <= 0 every cycle so the pipeline drains.
  - stall, flush and in_pc_src are ignored.
  - Exit only via reset.
- enable=0: PC, IF/ID and state all hold. Memory writes still occur.
- Reset mid-operation (including in HALTED or during stall): reset values apply on that edge and override every other input.
- Latency: an instruction at address A appears on out_instruccion one cycle after PC==A is presented.
- Branch penalty: one wrong-path slot, which the hazard unit removes via flush.

Optional Feature:
- Macro: IF_STEP_MODE_EN.
- When defined:
  - Adds input step (1 bit).
  - While enable=0, a one-cycle step pulse advances the stage exactly one fetch as if enable=1 for that edge.
  - A step held high for N cycles advances exactly one fetch (rising-edge detect on a registered copy).
  - When enable=1, step is ignored.
- When undefined: no step port; enable=0 freezes unconditionally.

Test Plan:
- Load imem[0..3]=0x20010005,0x20020007,0x00221820,0xFC000000 via wr_en, release reset, enable=1 → out_instruccion shows the words on cycles 1,2,3,4 with out_pc_branch=4,8,12,16.
- HALT fetched at PC=12 → out_halt=1 from cycle 5; out_pc stays 12; out_instruccion=0 on every later cycle; PC unchanged after 10 further cycles.
- stall=1 for 2 cycles at PC=8 → out_pc stays 8 and out_instruccion holds 0x20020007 for 2 cycles; fetch resumes at 8.
- in_pc_src=01, in_pc_branch=0x40, flush=1 with stall=1 → next PC=0x40, out_instruccion=0; the following cycle out_instruccion=imem[16], out_pc_branch=0x44.
- PC=0xFFFFFFFC sequential → next PC=0; fetch at 0x400 with IMEM_DEPTH=256 returns imem[0].
- enable=0 for 5 cycles with wr_en writing imem[5]=0xDEADBEEF → PC and IF/ID frozen; imem[5] updated. With IF_STEP_MODE_EN, one step pulse advances PC by exactly 4.
